// File: rtl/kpn_display_pkg.sv
// rtl/kpn_display_pkg.sv - glyphs, FSM states and helpers for the KPN display driver
package kpn_display_pkg;

  // Active-low gfedcba segment patterns
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONVERT,
    ST_WRITE
  } state_t;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    digit_to_seg = SEG_0;
      4'd1:    digit_to_seg = SEG_1;
      4'd2:    digit_to_seg = SEG_2;
      4'd3:    digit_to_seg = SEG_3;
      4'd4:    digit_to_seg = SEG_4;
      4'd5:    digit_to_seg = SEG_5;
      4'd6:    digit_to_seg = SEG_6;
      4'd7:    digit_to_seg = SEG_7;
      4'd8:    digit_to_seg = SEG_8;
      4'd9:    digit_to_seg = SEG_9;
      default: digit_to_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/kpn_display_driver_bin2bcd.sv
// rtl/kpn_display_driver_bin2bcd.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
  import kpn_display_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   bin,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    valid
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] bin_q;
  logic [BW-1:0]         bcd_q;
  logic [BW-1:0]         bcd_adj;
  logic [BW-1:0]         bcd_next;
  logic [CW-1:0]         count_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BW-2:0], bin_q[DATA_WIDTH-1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      bin_q   <= bin;
      bcd_q   <= '0;
      count_q <= CW'(DATA_WIDTH);
    end else if (count_q != '0) begin
      bin_q   <= {bin_q[DATA_WIDTH-2:0], 1'b0};
      bcd_q   <= bcd_next;
      count_q <= count_q - 1'b1;
    end
  end

  // bcd presents the post-shift value so the final step and valid coincide
  assign bcd   = bcd_next;
  assign valid = (count_q == CW'(1));

endmodule

// File: rtl/kpn_display_driver.sv
// rtl/kpn_display_driver.sv - KPN operand display: capture, BCD conversion, glyph output
module kpn_display_driver
  import kpn_display_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_LZ     = 1,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [CH_W-1:0]                    channel_select,
  input  logic                               entry_select,
  input  logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] operands,
  input  logic                               update_req,
  input  logic                               refresh_en,
  output logic                               busy,
  output logic                               done,
  output logic [13:0]                        hex_entry,
  output logic [13:0]                        hex_module,
  output logic [NUM_DIGITS*7-1:0]            hex_value
);

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  state_t                  state;
  logic [CH_W-1:0]         chan_q;
  logic                    entry_q;
  logic                    invalid_q;
  logic                    ovf_q;
  logic [DATA_WIDTH-1:0]   sel_operand;
  logic [NUM_DIGITS*4-1:0] conv_bcd;
  logic                    conv_valid;
  logic [13:0]             module_img;
  logic [NUM_DIGITS*7-1:0] value_img;
  logic                    leading;
  logic [3:0]              digit;
  logic [6:0]              seg;

  always_comb begin
    sel_operand = '0;
    for (int i = 0; i < 2 * NUM_CHANNELS; i++) begin
      if (int'(channel_select) * 2 + int'(entry_select) == i)
        sel_operand = operands[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  bin2bcd_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clock(clock),
    .reset(reset),
    .start(state == ST_LOAD),
    .bin  (sel_operand),
    .bcd  (conv_bcd),
    .valid(conv_valid)
  );

  always_comb begin
    if (invalid_q)          module_img = {SEG_BLANK, SEG_BLANK};
    else if (chan_q == '0)  module_img = {SEG_A, SEG_D};
    else if (chan_q == CH_W'(1)) module_img = {SEG_S, SEG_U};
    else                    module_img = {SEG_C, digit_to_seg(4'(chan_q))};
  end

  // Scan from the top digit; leading stays set until the first non-zero digit
  always_comb begin
    value_img = '0;
    leading   = 1'b1;
    digit     = '0;
    seg       = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = conv_bcd[i*4 +: 4];
      if (invalid_q) begin
        seg = SEG_DASH;
      end else if (ovf_q) begin
        seg = (i == NUM_DIGITS - 1) ? SEG_O : (i == NUM_DIGITS - 2) ? SEG_F : SEG_BLANK;
      end else begin
        if (digit != 4'd0 || i == 0) leading = 1'b0;
        seg = (BLANK_LZ != 0 && leading) ? SEG_BLANK : digit_to_seg(digit);
      end
      value_img[i*7 +: 7] = seg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      chan_q     <= '0;
      entry_q    <= 1'b0;
      invalid_q  <= 1'b0;
      ovf_q      <= 1'b0;
      hex_entry  <= {2{SEG_BLANK}};
      hex_module <= {2{SEG_BLANK}};
      hex_value  <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (update_req || refresh_en) begin
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          chan_q    <= channel_select;
          entry_q   <= entry_select;
          invalid_q <= int'(channel_select) >= NUM_CHANNELS;
          ovf_q     <= 64'(sel_operand) > MAX_VAL;
          state     <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (conv_valid) begin
            hex_entry  <= {SEG_E, entry_q ? SEG_2 : SEG_1};
            hex_module <= module_img;
            hex_value  <= value_img;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
